jtframe_rom_arb: RTL and testbench



---
 rtl/jtframe_rom_arb_pkg.sv | 32 +++
 rtl/jtframe_rom_arb_slot.sv | 37 +++
 rtl/jtframe_rom_arb.sv | 110 +++++++++++
 tb/tb_jtframe_rom_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types and grant helper for the SDRAM ROM arbiter.
package jtframe_rom_arb_pkg;

    localparam int ARB_MAX_SLOTS = 4;

    typedef logic [1:0] slot_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA
    } arb_st_t;

    // First set bit of cands scanning upward from last+1, wrapping. Slots
    // beyond the configured count are always zero, so wrapping on the full
    // width gives the same order as wrapping on the configured count.
    function automatic slot_idx_t rr_next(input logic [ARB_MAX_SLOTS-1:0] cands,
                                          input slot_idx_t last);
        slot_idx_t idx;
        logic      found;
        rr_next = last;
        found   = 1'b0;
        for (int k = 1; k <= ARB_MAX_SLOTS; k++) begin
            idx = last + slot_idx_t'(k);
            if (!found && cands[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/jtframe_rom_arb_slot.sv
// One requester's held word: stored address, data and the level ok flag.
module jtframe_rom_arb_slot
    import jtframe_rom_arb_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          load,
    input  logic [AW-1:0] gnt_addr,
    input  logic [DW-1:0] din,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic [AW-1:0] st_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ok      <= 1'b0;
            dout    <= '0;
            st_addr <= '0;
        end else if (load && cs && addr == gnt_addr && !clr) begin
            ok      <= 1'b1;
            dout    <= din;
            st_addr <= gnt_addr;
        end else if (clr || !cs || addr != st_addr) begin
            // the requester moved on or dropped out: the held word is stale
            ok <= 1'b0;
        end
    end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Round-robin sharing of the SDRAM read port among ROM requesters.
// Define JTFRAME_ROMARB_PRIO_EN for fixed priority (lowest slot wins).
module jtframe_rom_arb
    import jtframe_rom_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic               clk_rom,
    input  logic               rst,
    input  logic               downloading,
    input  logic               loop_rst,
    input  logic [SLOTS-1:0]   slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]   slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic               sdram_req,
    output logic [AW-1:0]      sdram_addr,
    input  logic               sdram_ack,
    input  logic [DW-1:0]      data_read,
    input  logic               data_rdy
);

    logic [SLOTS-1:0][AW-1:0]   addr_p;
    logic [ARB_MAX_SLOTS-1:0]   cands;
    logic                       halt;
    logic                       load;
    logic                       discard;
    slot_idx_t                  sel;
    slot_idx_t                  gnt_idx;
    logic [AW-1:0]              gnt_addr;
    arb_st_t                    st;

    assign addr_p = slot_addr;
    assign halt   = downloading | loop_rst;
    assign cands  = ARB_MAX_SLOTS'(slot_cs & ~slot_ok);
    assign load   = st == WAIT_DATA && data_rdy && !discard && !halt;

`ifdef JTFRAME_ROMARB_PRIO_EN
    assign sel = rr_next(cands, slot_idx_t'(ARB_MAX_SLOTS-1));
`else
    slot_idx_t last_grant;

    always_ff @(posedge clk_rom) begin
        if (rst)
            last_grant <= slot_idx_t'(SLOTS-1);
        else if (st == WAIT_DATA && data_rdy)
            last_grant <= gnt_idx;
    end

    assign sel = rr_next(cands, last_grant);
`endif

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            st         <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            gnt_idx    <= '0;
            gnt_addr   <= '0;
            discard    <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    discard <= 1'b0;
                    if (!halt && |cands) begin
                        gnt_idx    <= sel;
                        gnt_addr   <= addr_p[sel];
                        sdram_addr <= addr_p[sel];
                        sdram_req  <= 1'b1;
                        st         <= REQ;
                    end
                end
                REQ: begin
                    // a download seen at any point poisons this transaction
                    if (halt) discard <= 1'b1;
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        st        <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (halt) discard <= 1'b1;
                    if (data_rdy) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        jtframe_rom_arb_slot #(
            .AW(AW),
            .DW(DW)
        ) u_slot (
            .clk      (clk_rom),
            .rst      (rst),
            .clr      (halt),
            .cs       (slot_cs[i]),
            .addr     (addr_p[i]),
            .load     (load && gnt_idx == slot_idx_t'(i)),
            .gnt_addr (gnt_addr),
            .din      (data_read),
            .ok       (slot_ok[i]),
            .dout     (slot_dout[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed and randomized checks of the ROM arbiter against a slot-level model.
module tb_jtframe_rom_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic               clk_rom = 1'b0;
    logic               rst = 1'b1;
    logic               downloading = 1'b0;
    logic               loop_rst = 1'b0;
    logic [SLOTS-1:0]   slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]   slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic               sdram_req;
    logic [AW-1:0]      sdram_addr;
    logic               sdram_ack = 1'b0;
    logic [DW-1:0]      data_read = '0;
    logic               data_rdy = 1'b0;

    int checks = 0;
    int failures = 0;

    // model state: what each slot should be holding
    logic          m_ok   [SLOTS];
    logic [DW-1:0] m_dout [SLOTS];
    logic [AW-1:0] m_st   [SLOTS];
    int            m_last;

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_read   (data_read),
        .data_rdy    (data_rdy)
    );

    always #5 clk_rom = ~clk_rom;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_rom);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (a == 22'h001234) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return slot_addr[i*AW +: AW];
    endfunction

    task automatic set_slot(input int i, input logic cs, input logic [AW-1:0] a);
        slot_cs[i] = cs;
        slot_addr[i*AW +: AW] = a;
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_ok[i] = 1'b0; m_dout[i] = '0; m_st[i] = '0;
        end
        m_last = SLOTS - 1;
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < SLOTS; i++) m_ok[i] = 1'b0;
    endtask

    // ok drops for any slot no longer asking for what it holds
    task automatic sync_ok();
        for (int i = 0; i < SLOTS; i++)
            if (!slot_cs[i] || addr_of(i) != m_st[i]) m_ok[i] = 1'b0;
    endtask

    function automatic logic [SLOTS-1:0] model_cands();
        logic [SLOTS-1:0] c;
        for (int i = 0; i < SLOTS; i++) c[i] = slot_cs[i] && !m_ok[i];
        return c;
    endfunction

    function automatic int pick(input logic [SLOTS-1:0] c);
        int start;
`ifdef JTFRAME_ROMARB_PRIO_EN
        start = 0;
`else
        start = (m_last + 1) % SLOTS;
`endif
        for (int k = 0; k < SLOTS; k++)
            if (c[(start + k) % SLOTS]) return (start + k) % SLOTS;
        return -1;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < SLOTS; i++) begin
            chk($sformatf("%s_ok%0d", tag, i), 64'(slot_ok[i]), 64'(m_ok[i]));
            chk($sformatf("%s_dout%0d", tag, i), 64'(slot_dout[i*DW +: DW]), 64'(m_dout[i]));
        end
    endtask

    task automatic wait_req(input logic [AW-1:0] exp_addr);
        int n;
        n = 0;
        tick();
        while (!sdram_req && n < 40) begin tick(); n++; end
        chk("req_seen", 64'(sdram_req), 64'(1));
        chk("req_addr", 64'(sdram_addr), 64'(exp_addr));
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) tick();
        chk("req_held", 64'(sdram_req), 64'(1));
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("req_drop", 64'(sdram_req), 64'(0));
    endtask

    task automatic do_rdy(input int dly, input logic [DW-1:0] d);
        repeat (dly) tick();
        data_read = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        data_read = '0;
    endtask

    // one arbitration round following input changes made at this negedge
    task automatic step_serve(input int ack_d, input int rdy_d);
        logic [SLOTS-1:0] c;
        int               g;
        logic [AW-1:0]    a;
        c = model_cands();
        sync_ok();
        if (c == '0) c = model_cands();
        if (c == '0) begin
            repeat (3) begin
                tick();
                chk("no_req", 64'(sdram_req), 64'(0));
            end
            check_all("idle");
        end else begin
            g = pick(c);
            a = addr_of(g);
            wait_req(a);
            do_ack(ack_d);
            chk("ok_early", 64'(slot_ok[g]), 64'(0));
            do_rdy(rdy_d, rom(a));
            m_ok[g] = 1'b1; m_dout[g] = rom(a); m_st[g] = a; m_last = g;
            check_all("serve");
        end
    endtask

    initial begin
        logic [AW-1:0] pool [6];
        pool[0] = 22'h000010; pool[1] = 22'h000020; pool[2] = 22'h00ABCD;
        pool[3] = 22'h3FFFFF; pool[4] = 22'h000000; pool[5] = 22'h123456;
        model_reset();

        // reset state
        repeat (2) tick();
        chk("rst_ok", 64'(slot_ok), 64'(0));
        chk("rst_dout", 64'(slot_dout[63:0]), 64'(0));
        chk("rst_req", 64'(sdram_req), 64'(0));
        chk("rst_addr", 64'(sdram_addr), 64'(0));
        rst = 1'b0;
        tick();

        // single request
        set_slot(1, 1'b1, 22'h001234);
        step_serve(2, 5);
        chk("t1_ok", 64'(slot_ok), 64'(4'b0010));
        chk("t1_dout", 64'(slot_dout[63:32]), 64'(32'hDEADBEEF));

        // round-robin from reset: all four at once
        rst = 1'b1; slot_cs = '0;
        tick();
        rst = 1'b0; model_reset();
        set_slot(0, 1'b1, 22'h000010); set_slot(1, 1'b1, 22'h000020);
        set_slot(2, 1'b1, 22'h000030); set_slot(3, 1'b1, 22'h000040);
        for (int k = 0; k < SLOTS; k++) begin
            step_serve(k, 1);
            chk("rr_order", 64'(m_last), 64'(k));
        end
        set_slot(0, 1'b1, 22'h000011);
        step_serve(1, 2);
        chk("rr_regrant0", 64'(sdram_addr), 64'(22'h000011));
        chk("rr_held", 64'(slot_ok), 64'(4'b1111));

        // address change while waiting for data
        set_slot(2, 1'b1, 22'h000100);
        sync_ok();
        wait_req(22'h000100);
        do_ack(1);
        set_slot(2, 1'b1, 22'h000104);
        tick();
        do_rdy(2, rom(22'h000100));
        m_last = 2;
        sync_ok();
        chk("t3_ok2", 64'(slot_ok[2]), 64'(0));
        check_all("t3_discard");
        step_serve(1, 1);
        chk("t3_ok2_new", 64'(slot_ok[2]), 64'(1));
        chk("t3_dout2", 64'(slot_dout[95:64]), 64'(rom(22'h000104)));

        // download rising mid-fetch
        set_slot(1, 1'b1, 22'h000200);
        sync_ok();
        wait_req(22'h000200);
        do_ack(0);
        downloading = 1'b1;
        tick();
        chk("dl_ok_clr", 64'(slot_ok), 64'(0));
        do_rdy(1, rom(22'h000200));
        model_clear_all(); m_last = 1;
        check_all("dl_discard");
        repeat (5) begin
            tick();
            chk("dl_no_req", 64'(sdram_req), 64'(0));
        end
        downloading = 1'b0;
        repeat (SLOTS) step_serve(1, 1);

        // loop reset behaves like a download
        loop_rst = 1'b1;
        repeat (3) begin
            tick();
            chk("lr_no_req", 64'(sdram_req), 64'(0));
        end
        chk("lr_ok_clr", 64'(slot_ok), 64'(0));
        model_clear_all();
        loop_rst = 1'b0;
        repeat (SLOTS) step_serve(0, 0);

        // reset while in REQ
        set_slot(0, 1'b1, 22'h000300);
        sync_ok();
        wait_req(22'h000300);
        rst = 1'b1; slot_cs = '0;
        tick();
        rst = 1'b0; model_reset();
        chk("mr_ok", 64'(slot_ok), 64'(0));
        chk("mr_dout", 64'(slot_dout[127:64]), 64'(0));
        chk("mr_req", 64'(sdram_req), 64'(0));
        chk("mr_addr", 64'(sdram_addr), 64'(0));
        repeat (2) tick();
        do_rdy(0, 32'h0BADF00D);
        tick();
        chk("mr_stray_ok", 64'(slot_ok), 64'(0));
        chk("mr_stray_req", 64'(sdram_req), 64'(0));

        // held data
        set_slot(3, 1'b1, 22'h0003F0);
        step_serve(1, 3);
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("hold_ok3", 64'(slot_ok[3]), 64'(1));
            chk("hold_no_req", 64'(sdram_req), 64'(0));
        end
        slot_cs[3] = 1'b0;
        tick();
        chk("hold_cs_drop", 64'(slot_ok[3]), 64'(0));
        sync_ok();

        // randomized traffic
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < SLOTS; i++)
                if ($urandom_range(0, 2) == 0)
                    set_slot(i, $urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)]);
            step_serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
